// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the MIPS-subset core.
// Latches one instruction from fetch, steps FETCH/DECODE/EXEC/MEM/WB and
// issues datapath strobes per state. Mul/div stretch EXEC, loads and stores
// wait for mem_ack with a timeout, and undecodable words park in TRAP.
module multicycle_control_unit #(
    parameter int unsigned MULDIV_LAT  = 4,     // extra EXEC cycles for mul/div
    parameter int unsigned MEM_TIMEOUT = 8,     // MEM cycles allowed before trap
    parameter bit          EN_MULDIV   = 1'b1   // 0: mul/div decode as illegal
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr_in,
    output logic        instr_ready,
    input  logic        mem_ack,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm,
    output logic [25:0] address,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        MemRead,
    output logic        RegDst,
    output logic        ALUSrc,
    output logic        Branch,
    output logic [1:0]  ALUOp,
    output logic [1:0]  PCSrc,
    output logic        pc_write,
    output logic        muldiv_busy,
    output logic        illegal,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LI    = 6'b100111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_MUL = 6'b011000;
    localparam logic [5:0] F_DIV = 6'b011010;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_XOR = 6'b100110;

    localparam logic [3:0] LAT      = 4'(MULDIV_LAT);
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [3:0]  busy_cnt_q, busy_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        illegal_q, illegal_d;

    logic        is_rtype, is_muldiv, rtype_ok, legal;

    // Instruction fields come straight off the registered IR.
    assign opcode  = ir_q[31:26];
    assign rs      = ir_q[25:21];
    assign rt      = ir_q[20:16];
    assign rd      = ir_q[15:11];
    assign shamt   = ir_q[10:6];
    assign funct   = ir_q[5:0];
    assign imm     = ir_q[15:0];
    assign address = ir_q[25:0];
    assign state   = state_q;

    // Instruction class and legality from the registered IR.
    always_comb begin
        is_rtype  = (ir_q[31:26] == OP_RTYPE);
        is_muldiv = is_rtype && ((ir_q[5:0] == F_MUL) || (ir_q[5:0] == F_DIV));
        case (ir_q[5:0])
            F_ADD, F_SUB, F_SLL, F_SRL,
            F_OR, F_AND, F_NOR, F_XOR: rtype_ok = 1'b1;
            F_MUL, F_DIV:              rtype_ok = EN_MULDIV;
            default:                   rtype_ok = 1'b0;
        endcase
        case (ir_q[31:26])
            OP_RTYPE:                    legal = rtype_ok;
            OP_ADDI, OP_LI, OP_LW,
            OP_SW, OP_BEQ, OP_J:         legal = 1'b1;
            default:                     legal = 1'b0;
        endcase
    end

    // Next-state, counters and per-state control strobes.
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        busy_cnt_d  = busy_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        instr_ready = 1'b0;
        RegWrite    = 1'b0;
        MemWrite    = 1'b0;
        MemRead     = 1'b0;
        RegDst      = 1'b0;
        ALUSrc      = 1'b0;
        Branch      = 1'b0;
        ALUOp       = 2'b00;
        PCSrc       = 2'b00;
        pc_write    = 1'b0;
        muldiv_busy = 1'b0;
        illegal     = illegal_q;

        case (state_q)
            S_FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ir_d    = instr_in;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                busy_cnt_d = '0;
                wait_cnt_d = '0;
                state_d    = legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                case (ir_q[31:26])
                    OP_RTYPE: begin
                        RegDst = 1'b1;
                        ALUOp  = 2'b10;
                        // mul/div hold EXEC; busy drops in the last EXEC cycle
                        if (is_muldiv && (busy_cnt_q != LAT)) begin
                            muldiv_busy = 1'b1;
                            busy_cnt_d  = busy_cnt_q + 4'd1;
                        end else begin
                            state_d = S_WB;
                        end
                    end
                    OP_ADDI, OP_LI: begin
                        ALUSrc  = 1'b1;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        ALUSrc  = 1'b1;
                        state_d = S_MEM;
                    end
                    OP_BEQ: begin
                        // PC update is qualified by the ALU zero flag in the datapath
                        ALUOp    = 2'b01;
                        Branch   = 1'b1;
                        PCSrc    = 2'b01;
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                    OP_J: begin
                        PCSrc    = 2'b10;
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                MemRead  = (ir_q[31:26] == OP_LW);
                MemWrite = (ir_q[31:26] == OP_SW);
                if (mem_ack) begin
                    if (ir_q[31:26] == OP_LW) begin
                        state_d = S_WB;
                    end else begin
                        // a store retires on the ack cycle, so PC advances right away
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                end else if (wait_cnt_q == TMO_LAST) begin
                    state_d = S_TRAP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                pc_write = 1'b1;
                RegDst   = is_rtype;
                state_d  = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: state_d = S_TRAP;
        endcase

        illegal_d = illegal_q | (state_d == S_TRAP);

        // reset kills whatever is in flight: nothing is issued this cycle
        if (rst) begin
            instr_ready = 1'b0;
            RegWrite    = 1'b0;
            MemWrite    = 1'b0;
            MemRead     = 1'b0;
            RegDst      = 1'b0;
            ALUSrc      = 1'b0;
            Branch      = 1'b0;
            ALUOp       = 2'b00;
            PCSrc       = 2'b00;
            pc_write    = 1'b0;
            muldiv_busy = 1'b0;
            illegal     = 1'b0;
        end
    end

    // State, IR, counters and sticky trap flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            ir_q       <= '0;
            busy_cnt_q <= '0;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            busy_cnt_q <= busy_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: each stimulus cycle queues the expected state/strobes,
// a negedge monitor pops and compares. A second instance with mul/div
// disabled shares all inputs and is checked where tagged.
module tb_multicycle_control_unit;

    logic clk = 1'b0;
    logic rst, instr_valid, mem_ack;
    logic [31:0] instr_in;

    always #5 clk = ~clk;

    // dut outputs
    logic        instr_ready, RegWrite, MemWrite, MemRead, RegDst, ALUSrc, Branch, pc_write, muldiv_busy, illegal;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] address;
    logic [1:0]  ALUOp, PCSrc;
    logic [2:0]  state;
    // dut2 outputs
    logic        instr_ready_2, RegWrite_2, MemWrite_2, MemRead_2, RegDst_2, ALUSrc_2, Branch_2, pc_write_2, muldiv_busy_2, illegal_2;
    logic [5:0]  opcode_2, funct_2;
    logic [4:0]  rs_2, rt_2, rd_2, shamt_2;
    logic [15:0] imm_2;
    logic [25:0] address_2;
    logic [1:0]  ALUOp_2, PCSrc_2;
    logic [2:0]  state_2;

    multicycle_control_unit #(.MULDIV_LAT(4), .MEM_TIMEOUT(8), .EN_MULDIV(1'b1)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_in(instr_in), .instr_ready(instr_ready),
        .mem_ack(mem_ack), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm(imm), .address(address), .RegWrite(RegWrite), .MemWrite(MemWrite), .MemRead(MemRead),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .Branch(Branch), .ALUOp(ALUOp), .PCSrc(PCSrc),
        .pc_write(pc_write), .muldiv_busy(muldiv_busy), .illegal(illegal), .state(state));

    multicycle_control_unit #(.MULDIV_LAT(4), .MEM_TIMEOUT(8), .EN_MULDIV(1'b0)) dut2 (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_in(instr_in), .instr_ready(instr_ready_2),
        .mem_ack(mem_ack), .opcode(opcode_2), .rs(rs_2), .rt(rt_2), .rd(rd_2), .shamt(shamt_2), .funct(funct_2),
        .imm(imm_2), .address(address_2), .RegWrite(RegWrite_2), .MemWrite(MemWrite_2), .MemRead(MemRead_2),
        .RegDst(RegDst_2), .ALUSrc(ALUSrc_2), .Branch(Branch_2), .ALUOp(ALUOp_2), .PCSrc(PCSrc_2),
        .pc_write(pc_write_2), .muldiv_busy(muldiv_busy_2), .illegal(illegal_2), .state(state_2));

    // strobe vector: rdy RW MW MR RD AS BR ALUOp[2] PCSrc[2] PW BUSY ILL
    logic [13:0] obs1, obs2;
    assign obs1 = {instr_ready, RegWrite, MemWrite, MemRead, RegDst, ALUSrc, Branch, ALUOp, PCSrc, pc_write, muldiv_busy, illegal};
    assign obs2 = {instr_ready_2, RegWrite_2, MemWrite_2, MemRead_2, RegDst_2, ALUSrc_2, Branch_2, ALUOp_2, PCSrc_2, pc_write_2, muldiv_busy_2, illegal_2};

    localparam logic [13:0] NONE = 14'd0;
    localparam logic [13:0] RDY  = 14'b1 << 13;
    localparam logic [13:0] RW   = 14'b1 << 12;
    localparam logic [13:0] MW   = 14'b1 << 11;
    localparam logic [13:0] MR   = 14'b1 << 10;
    localparam logic [13:0] RD   = 14'b1 << 9;
    localparam logic [13:0] AS   = 14'b1 << 8;
    localparam logic [13:0] BR   = 14'b1 << 7;
    localparam logic [13:0] OPF  = 14'b1 << 6;   // ALUOp=10
    localparam logic [13:0] OPS  = 14'b1 << 5;   // ALUOp=01
    localparam logic [13:0] PCJ  = 14'b1 << 4;   // PCSrc=10
    localparam logic [13:0] PCB  = 14'b1 << 3;   // PCSrc=01
    localparam logic [13:0] PW   = 14'b1 << 2;
    localparam logic [13:0] BSY  = 14'b1 << 1;
    localparam logic [13:0] ILL  = 14'b1;

    localparam logic [2:0] FE = 3'd0, DE = 3'd1, EX = 3'd2, ME = 3'd3, WB = 3'd4, TR = 3'd7;

    localparam logic [31:0] I_ADD = 32'h0022_1820;
    localparam logic [31:0] I_LW  = 32'h8C25_0004;
    localparam logic [31:0] I_SW  = 32'hAC25_0004;
    localparam logic [31:0] I_MUL = 32'h0022_1818;
    localparam logic [31:0] I_J   = 32'h0800_0010;
    localparam logic [31:0] I_BEQ = 32'h1022_0003;
    localparam logic [31:0] I_BAD = 32'hFC00_0000;

    typedef struct {
        logic        c2;
        logic [2:0]  st;
        logic [13:0] sb;
        logic        chkf;
        logic [31:0] fw;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // one stimulus cycle: drive inputs just after the edge, queue what must be seen
    task automatic cyc(input logic r, input logic v, input logic [31:0] ins, input logic ack,
                       input logic [2:0] st, input logic [13:0] sb, input string nm,
                       input logic c2 = 1'b0, input logic chkf = 1'b0);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; instr_valid = v; instr_in = ins; mem_ack = ack;
        e.c2 = c2; e.st = st; e.sb = sb; e.chkf = chkf; e.fw = ins; e.nm = nm;
        if (chkf) e.fw = ins;
        exp_q.push_back(e);
    endtask

    // field checks need the expected word independently of what is driven
    task automatic cyc_f(input logic [31:0] fw, input logic [2:0] st, input logic [13:0] sb, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst = 1'b0; instr_valid = 1'b0; instr_in = 32'h0; mem_ack = 1'b0;
        e.c2 = 1'b0; e.st = st; e.sb = sb; e.chkf = 1'b1; e.fw = fw; e.nm = nm;
        exp_q.push_back(e);
    endtask

    // monitor: compare whatever is due this cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [2:0]  ast;
            logic [13:0] asb;
            e   = exp_q.pop_front();
            ast = e.c2 ? state_2 : state;
            asb = e.c2 ? obs2 : obs1;
            n_chk++;
            if ({ast, asb} !== {e.st, e.sb}) begin
                n_fail++;
                $display("FAIL %s: got state=%0d strobes=%b, want state=%0d strobes=%b",
                         e.nm, ast, asb, e.st, e.sb);
            end
            if (e.chkf) begin
                n_chk++;
                if ({opcode, rs, rt, rd, shamt, funct} !== e.fw || imm !== e.fw[15:0] || address !== e.fw[25:0]) begin
                    n_fail++;
                    $display("FAIL %s fields: got op=%h rs=%0d rt=%0d rd=%0d sh=%0d fn=%h imm=%h addr=%h, want word %h",
                             e.nm, opcode, rs, rt, rd, shamt, funct, imm, address, e.fw);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr_in = 32'h0; mem_ack = 1'b0;

        // reset: state FETCH, nothing issued, fields cleared
        cyc(1, 0, 0, 0, FE, NONE, "reset");
        cyc(1, 1, I_ADD, 1, FE, NONE, "reset_hold");
        cyc_f(32'h0, FE, RDY, "post_reset");

        // add with instr_valid held through the instruction
        cyc(0, 1, I_ADD, 0, FE, RDY, "add_fetch");
        cyc(0, 1, I_ADD, 0, DE, NONE, "add_decode", 1'b0, 1'b1);
        cyc(0, 1, I_ADD, 0, EX, RD | OPF, "add_exec");
        cyc(0, 1, I_ADD, 0, WB, RW | RD | PW, "add_wb");
        cyc(0, 0, 0, 0, FE, RDY, "add_ready");

        // lw with ack on the third MEM cycle
        cyc(0, 1, I_LW, 0, FE, RDY, "lw_fetch");
        cyc_f(I_LW, DE, NONE, "lw_decode");
        cyc(0, 0, 0, 0, EX, AS, "lw_exec");
        cyc(0, 0, 0, 0, ME, MR, "lw_mem1");
        cyc(0, 0, 0, 0, ME, MR, "lw_mem2");
        cyc(0, 0, 0, 1, ME, MR, "lw_mem3");
        cyc(0, 0, 0, 0, WB, RW | PW, "lw_wb");
        cyc(0, 0, 0, 0, FE, RDY, "lw_done");

        // sw with zero-wait ack; stray ack in EXEC must be ignored
        cyc(0, 1, I_SW, 0, FE, RDY, "sw_fetch");
        cyc(0, 0, 0, 0, DE, NONE, "sw_decode");
        cyc(0, 0, 0, 1, EX, AS, "sw_exec");
        cyc(0, 0, 0, 1, ME, MW | PW, "sw_mem");
        cyc(0, 0, 0, 0, FE, RDY, "sw_done");

        // mul: 4 busy EXEC cycles, one final EXEC, WB on cycle 8
        cyc(0, 1, I_MUL, 0, FE, RDY, "mul_fetch");
        cyc(0, 0, 0, 0, DE, NONE, "mul_decode");
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, EX, RD | OPF | BSY, $sformatf("mul_busy%0d", i));
        cyc(0, 0, 0, 0, EX, RD | OPF, "mul_exec_last");
        cyc(0, 0, 0, 0, WB, RW | RD | PW, "mul_wb");
        // instance without mul/div trapped on the same word
        cyc(0, 0, 0, 0, TR, ILL, "nomuldiv_trap", 1'b1);
        cyc(0, 0, 0, 0, FE, RDY, "mul_done");
        cyc(1, 0, 0, 0, TR, NONE, "nomuldiv_rst", 1'b1);
        cyc(0, 0, 0, 0, FE, RDY, "nomuldiv_cleared", 1'b1);

        // j
        cyc(0, 1, I_J, 0, FE, RDY, "j_fetch");
        cyc_f(I_J, DE, NONE, "j_decode");
        cyc(0, 0, 0, 0, EX, PCJ | PW, "j_exec");
        cyc(0, 0, 0, 0, FE, RDY, "j_done");

        // beq
        cyc(0, 1, I_BEQ, 0, FE, RDY, "beq_fetch");
        cyc(0, 0, 0, 0, DE, NONE, "beq_decode");
        cyc(0, 0, 0, 0, EX, BR | OPS | PCB | PW, "beq_exec");
        cyc(0, 0, 0, 0, FE, RDY, "beq_done");

        // illegal opcode: sticky trap ignoring instr_valid, cleared by rst
        cyc(0, 1, I_BAD, 0, FE, RDY, "bad_fetch");
        cyc(0, 1, I_ADD, 0, DE, NONE, "bad_decode");
        for (int i = 0; i < 20; i++) cyc(0, 1, I_ADD, 1, TR, ILL, $sformatf("bad_trap%0d", i));
        cyc(1, 0, 0, 0, TR, NONE, "bad_rst");
        cyc(0, 0, 0, 0, FE, RDY, "bad_cleared");

        // lw timeout: 8 MEM cycles without ack, then trap
        cyc(0, 1, I_LW, 0, FE, RDY, "tmo_fetch");
        cyc(0, 0, 0, 0, DE, NONE, "tmo_decode");
        cyc(0, 0, 0, 0, EX, AS, "tmo_exec");
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, ME, MR, $sformatf("tmo_mem%0d", i));
        cyc(0, 0, 0, 1, TR, ILL, "tmo_trap");
        cyc(0, 0, 0, 0, TR, ILL, "tmo_trap_hold");
        cyc(1, 0, 0, 0, TR, NONE, "tmo_rst");
        cyc(0, 0, 0, 0, FE, RDY, "tmo_cleared");

        // rst in the middle of MEM aborts with nothing issued
        cyc(0, 1, I_LW, 0, FE, RDY, "abort_fetch");
        cyc(0, 0, 0, 0, DE, NONE, "abort_decode");
        cyc(0, 0, 0, 0, EX, AS, "abort_exec");
        cyc(0, 0, 0, 0, ME, MR, "abort_mem1");
        cyc(1, 0, 0, 1, ME, NONE, "abort_rst");
        cyc(0, 0, 0, 0, FE, RDY, "abort_fetch_after");

        // ack on the last allowed MEM cycle is still taken
        cyc(0, 1, I_LW, 0, FE, RDY, "edge_fetch");
        cyc(0, 0, 0, 0, DE, NONE, "edge_decode");
        cyc(0, 0, 0, 0, EX, AS, "edge_exec");
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, ME, MR, $sformatf("edge_mem%0d", i));
        cyc(0, 0, 0, 1, ME, MR, "edge_mem_ack");
        cyc(0, 0, 0, 0, WB, RW | PW, "edge_wb");
        cyc(0, 0, 0, 0, FE, RDY, "edge_done");

        @(negedge clk);
        #1;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
